// File: rtl/ram_bank.sv
// Multi-read-port RAM with byte-enable writes and registered reads.
// A sweep FSM writes CLEAR_VAL to every word after reset and on clr_req.
module ram_bank #(
  parameter int               WIDTH     = 32,
  parameter int               WORD_SIZE = 8,
  parameter int               BYTE_W    = 8,
  parameter int               RD_PORTS  = 2,
  parameter int               RDW_MODE  = 0,
  parameter logic [WIDTH-1:0] CLEAR_VAL = '0
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [WORD_SIZE-1:0]          wr_addr,
  input  logic [WIDTH/BYTE_W-1:0]       wr_be,
  input  logic [WIDTH-1:0]              data_in,
  input  logic [RD_PORTS-1:0]           rd_en,
  input  logic [RD_PORTS*WORD_SIZE-1:0] rd_addr,
  output logic [RD_PORTS*WIDTH-1:0]     data_out,
  output logic [RD_PORTS-1:0]           rd_valid,
  input  logic                          clr_req,
  output logic                          busy
);
  localparam int NBE   = WIDTH / BYTE_W;
  localparam int DEPTH = 2 ** WORD_SIZE;

  typedef enum logic {CLEAR, READY} state_e;

  state_e               state_q, state_d;
  logic [WORD_SIZE-1:0] clr_ptr_q, clr_ptr_d;
  logic [WIDTH-1:0]     mem [DEPTH];
  logic [WIDTH-1:0]     wr_merged;
  logic                 ready;

  assign ready = (state_q == READY);
  assign busy  = ~ready;

  // Byte-merged post-write word; also the bypass source for RDW_MODE=1.
  always_comb begin
    wr_merged = mem[wr_addr];
    for (int k = 0; k < NBE; k++)
      if (wr_be[k]) wr_merged[k*BYTE_W +: BYTE_W] = data_in[k*BYTE_W +: BYTE_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    case (state_q)
      CLEAR: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == '1) begin
          state_d   = READY;
          clr_ptr_d = '0;
        end
      end
      READY: if (clr_req) state_d = CLEAR;
      default: state_d = CLEAR;
    endcase
  end

  // Storage has no reset; the sweep is the only way it gets initialised.
  always_ff @(posedge clk) begin
    if (!ready)     mem[clr_ptr_q] <= CLEAR_VAL;
    else if (wr_en) mem[wr_addr]   <= wr_merged;
  end

  for (genvar gp = 0; gp < RD_PORTS; gp++) begin : g_rd
    logic [WORD_SIZE-1:0] addr;
    logic                 hit;
    logic [WIDTH-1:0]     dout_q;
    logic                 vld_q;

    assign addr = rd_addr[gp*WORD_SIZE +: WORD_SIZE];
    assign hit  = (RDW_MODE != 0) && wr_en && (addr == wr_addr);

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_q <= '0;
        vld_q  <= 1'b0;
      end else begin
        vld_q <= ready && rd_en[gp];
        if (ready && rd_en[gp]) dout_q <= hit ? wr_merged : mem[addr];
      end
    end

    assign data_out[gp*WIDTH +: WIDTH] = dout_q;
    assign rd_valid[gp]                = vld_q;
  end
endmodule

// File: tb/tb_ram_bank.sv
// Scoreboard bench: two DUTs (old-data and bypass read-during-write) driven
// by the same stimulus, checked every cycle against a behavioural model.
module tb_ram_bank;
  localparam int D = 16;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        wr_en = 1'b0, clr_req = 1'b0;
  logic [3:0]  wr_addr = '0, wr_be = '0;
  logic [31:0] data_in = '0;
  logic [1:0]  rd_en = '0;
  logic [7:0]  rd_addr = '0;
  logic [63:0] dout0, dout1;
  logic [1:0]  vld0, vld1;
  logic        busy0, busy1;

  ram_bank #(.WIDTH(32), .WORD_SIZE(4), .BYTE_W(8), .RD_PORTS(2), .RDW_MODE(0), .CLEAR_VAL(32'h0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .data_in(data_in),
    .rd_en(rd_en), .rd_addr(rd_addr), .data_out(dout0), .rd_valid(vld0), .clr_req(clr_req), .busy(busy0));
  ram_bank #(.WIDTH(32), .WORD_SIZE(4), .BYTE_W(8), .RD_PORTS(2), .RDW_MODE(1), .CLEAR_VAL(32'h0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .data_in(data_in),
    .rd_en(rd_en), .rd_addr(rd_addr), .data_out(dout1), .rd_valid(vld1), .clr_req(clr_req), .busy(busy1));

  always #5 clk = ~clk;

  typedef struct { logic busy; logic [1:0] vld; logic [63:0] d0; logic [63:0] d1; } exp_t;
  exp_t exp_q[$];
  int   n_tests = 0, n_fail = 0;

  // Reference model: array of words, a sweep countdown, per-mode read regs.
  logic [31:0] m_mem [D];
  logic [31:0] m_dout [2][2];
  logic [1:0]  m_vld;
  bit          m_busy;
  int          m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b1; m_cnt = 0; m_vld = '0;
    for (int m = 0; m < 2; m++) for (int p = 0; p < 2; p++) m_dout[m][p] = '0;
  endtask

  task automatic model_edge();
    logic [31:0] nw;
    logic [3:0]  a;
    if (!rst_n) model_reset();
    else if (m_busy) begin
      m_mem[m_cnt] = 32'h0;
      m_cnt++;
      m_vld = '0;
      if (m_cnt == D) begin m_busy = 1'b0; m_cnt = 0; end
    end else begin
      nw = m_mem[wr_addr];
      for (int k = 0; k < 4; k++) if (wr_be[k]) nw[k*8 +: 8] = data_in[k*8 +: 8];
      for (int p = 0; p < 2; p++) begin
        a = rd_addr[p*4 +: 4];
        m_vld[p] = rd_en[p];
        if (rd_en[p]) begin
          m_dout[0][p] = m_mem[a];
          m_dout[1][p] = (wr_en && a == wr_addr) ? nw : m_mem[a];
        end
      end
      if (wr_en) m_mem[wr_addr] = nw;
      if (clr_req) begin m_busy = 1'b1; m_cnt = 0; end
    end
  endtask

  // Called just after a falling edge; returns just after the next one.
  task automatic step(input logic we, input logic [3:0] wa, input logic [3:0] be, input logic [31:0] di,
                      input logic [1:0] re, input logic [7:0] ra, input logic cr);
    exp_t e;
    wr_en = we; wr_addr = wa; wr_be = be; data_in = di; rd_en = re; rd_addr = ra; clr_req = cr;
    model_edge();
    e.busy = m_busy; e.vld = m_vld;
    e.d0 = {m_dout[0][1], m_dout[0][0]};
    e.d1 = {m_dout[1][1], m_dout[1][0]};
    @(posedge clk); #1;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic rand_step(input logic allow_clr);
    step(1'($urandom), 4'($urandom), 4'($urandom), $urandom, 2'($urandom), 8'($urandom),
         allow_clr && ($urandom_range(0, 49) == 0));
  endtask

  task automatic read_all();
    for (int i = 0; i < D; i++) step(1'b0, 4'h0, 4'h0, 32'h0, 2'b11, {4'(D-1-i), 4'(i)}, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("busy_m0", 64'(busy0), 64'(e.busy));
        chk("busy_m1", 64'(busy1), 64'(e.busy));
        chk("rd_valid_m0", 64'(vld0), 64'(e.vld));
        chk("rd_valid_m1", 64'(vld1), 64'(e.vld));
        chk("data_out_m0", dout0, e.d0);
        chk("data_out_m1", dout1, e.d1);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int guard;
    for (int i = 0; i < D; i++) m_mem[i] = 32'h0;
    model_reset();
    @(negedge clk);
    repeat (3) rand_step(1'b1);
    rst_n = 1'b1;
    repeat (D) rand_step(1'b1);          // sweep: everything ignored
    read_all();

    for (int i = 0; i < 8; i++) step(1'b1, 4'(i), 4'hF, 32'((i + 1) * 11), 2'b00, 8'h0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 4'h0, 4'h0, 32'h0, 2'b11, {4'(7 - i), 4'(i)}, 1'b0);
    step(1'b0, 4'h0, 4'h0, 32'h0, 2'b00, 8'h0, 1'b0);   // valid drops, data holds

    step(1'b1, 4'd3, 4'hF,    32'hAABBCCDD, 2'b00, 8'h0, 1'b0);
    step(1'b1, 4'd3, 4'b0101, 32'h11223344, 2'b00, 8'h0, 1'b0);
    step(1'b0, 4'd0, 4'h0,    32'h0,        2'b01, 8'h03, 1'b0);

    step(1'b1, 4'd9, 4'hF, 32'h1, 2'b00, 8'h00, 1'b0);
    step(1'b1, 4'd9, 4'hF, 32'h5, 2'b11, 8'h99, 1'b0);  // same-edge RDW
    step(1'b0, 4'd0, 4'h0, 32'h0, 2'b11, 8'h99, 1'b0);

    step(1'b1, 4'd2, 4'hF, 32'hFF, 2'b11, 8'h23, 1'b1); // clr_req with write+read
    repeat (D) rand_step(1'b1);
    read_all();

    repeat (200) rand_step(1'b1);
    guard = 0;
    while (m_busy && guard < 40) begin rand_step(1'b0); guard++; end
    chk("idle_before_reset_test", 64'(m_busy), 64'(0));
    for (int i = 0; i < 4; i++) step(1'b0, 4'h0, 4'h0, 32'h0, 2'b11, {$urandom} % 256, 1'b0);
    step(1'b0, 4'h0, 4'h0, 32'h0, 2'b00, 8'h0, 1'b1);
    repeat (5) rand_step(1'b1);

    rst_n = 1'b0;                        // mid-sweep, away from a clock edge
    #1;
    chk("async_busy_m0", 64'(busy0), 64'(1));
    chk("async_busy_m1", 64'(busy1), 64'(1));
    chk("async_valid", {62'(0), vld0 | vld1}, 64'(0));
    chk("async_dout_m0", dout0, 64'(0));
    chk("async_dout_m1", dout1, 64'(0));
    model_reset();
    @(negedge clk);
    repeat (2) rand_step(1'b1);
    rst_n = 1'b1;
    repeat (D) rand_step(1'b1);
    read_all();
    repeat (50) rand_step(1'b1);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_bank.md
# ram_bank

Parametrised multi-read-port RAM with byte-enable writes, registered reads with valid flags, and a built-in clear engine. It is the next-generation storage block for the CPU datapath: a register file or scratchpad instance uses RD_PORTS=2, and the data memory uses RD_PORTS=1. The flop-less array cannot be reset directly, so a sweep FSM initialises every word to CLEAR_VAL after reset and on request.

## Interface
- WIDTH, 32, data word width in bits; must be a multiple of BYTE_W
- WORD_SIZE, 8, address width; depth = 2**WORD_SIZE
- BYTE_W, 8, bits per write-enable lane; NBE = WIDTH/BYTE_W lanes
- RD_PORTS, 2, number of independent read ports (1..4)
- RDW_MODE, 0, same-address read-during-write: 0 = old data, 1 = new (merged) data
- CLEAR_VAL, 0, WIDTH-bit value written to every word by the clear engine

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous assert, active-low
- wr_en  in  1  write request
- wr_addr  in  WORD_SIZE  write address
- wr_be  in  NBE  byte-lane enables; lane k covers data_in[k*BYTE_W +: BYTE_W]
- data_in  in  WIDTH  write data
- rd_en  in  RD_PORTS  per-port read request
- rd_addr  in  RD_PORTS*WORD_SIZE  port p address at [p*WORD_SIZE +: WORD_SIZE]
- data_out  out  RD_PORTS*WIDTH  port p data at [p*WIDTH +: WIDTH], registered
- rd_valid  out  RD_PORTS  port p data_out was updated by the previous edge
- clr_req  in  1  start a clear sweep (single-cycle pulse or level)
- busy  out  1  clear sweep in progress; user reads and writes are ignored

## Operation
- FSM states: CLEAR, READY.
- Reset forces CLEAR, sets clr_ptr=0, data_out=0, rd_valid=0, and busy=1.
- CLEAR: on each edge, write CLEAR_VAL to mem[clr_ptr] and increment clr_ptr.
  - When clr_ptr == 2**WORD_SIZE-1 is written, go to READY and reset clr_ptr to 0.
  - busy=1 throughout; wr_en, rd_en, and clr_req are ignored; rd_valid=0.
- READY: busy=0.
  - clr_req=1 sampled at an edge moves the FSM to CLEAR.
  - A user write or read sampled on that same edge still completes.
- Write (READY, wr_en=1): for each lane k with wr_be[k]=1, mem[wr_addr] lane k <= data_in lane k. Other lanes keep their old value.
  - wr_be=0 with wr_en=1 is a no-op.
- Read (READY, rd_en[p]=1):
  - data_out port p <= mem[rd_addr_p] and rd_valid[p] <= 1.
  - If rd_en[p]=0: data_out port p holds its value and rd_valid[p] <= 0.
- Read-during-write with rd_addr_p == wr_addr on the same edge:
  - RDW_MODE=0: port returns the pre-write word.
  - RDW_MODE=1: port returns the byte-merged post-write word (bypass).
  - Different addresses never interact.
- Multiple read ports may address the same or different words in the same cycle; no arbitration and no stall.
- Addresses cover the full power-of-two depth, so there is no out-of-range case. clr_ptr wraps only through the CLEAR→READY transition.

## Timing
- Read latency is 1 edge: request sampled at edge N; data_out/rd_valid are valid after edge N until edge N+1.
- Write is visible to a read sampled at edge N+1 or later (or at edge N when RDW_MODE=1).
- Clear sweep takes exactly 2**WORD_SIZE edges.
  - busy is low after the 2**WORD_SIZE-th edge following rst_n deassertion or following the edge that sampled clr_req.
  - The first edge with rst_n=1 writes address 0.
- Reset asserted mid-sweep or mid-read: outputs go to reset values immediately (asynchronously). The sweep restarts from address 0 after deassertion.
- clr_req while busy=1 is ignored; it does not extend or restart the sweep.

## Test plan
Parameters: WIDTH=32, WORD_SIZE=4, RD_PORTS=2, BYTE_W=8, CLEAR_VAL=0.

- Release reset and count edges.
  - Expect busy=1 for exactly 16 edges, then 0.
  - Read all 16 addresses on both ports: every data_out=0 with rd_valid=1 one edge after each request.
- Write 11,22,…,88 to addresses 0–7 with wr_be=4'hF, then read port0 addr i and port1 addr 7-i.
  - Expect matching values one edge later on both ports.
  - rd_valid drops the edge after rd_en drops, and data_out holds.
- Write 32'hAABBCCDD to addr 3 with wr_be=4'hF, then write 32'h11223344 with wr_be=4'b0101.
  - A read of addr 3 returns 32'hAA22CC44.
- Same-edge write 32'h5 and read of addr 9, where addr 9 previously held 32'h1.
  - RDW_MODE=0 returns 32'h1.
  - RDW_MODE=1 returns 32'h5.
  - A following read returns 32'h5 in both modes.
- With memory loaded, pulse clr_req along with a write of 32'hFF to addr 2.
  - Write completes; busy=1 for 16 edges.
  - Writes and reads issued during busy are ignored (rd_valid=0).
  - Afterwards every address reads 0.
- Assert rst_n low after 5 sweep edges.
  - busy, rd_valid, and data_out go to reset values immediately.
  - After release, the sweep takes the full 16 edges again.
